hour_keeper: RTL and testbench

Registered BCD hour-of-day counter for the clock datapath, the sequential successor to the combinational 24h→12h hour formatter. Advances on the minute-rollover carry, accepts manual set/increment/decrement from the button layer, and drives a registered display hour in either 24h or 12h form with the AM/PM/24h indicator code. Indicator codes and reset hour are parameters, so display boards with different segment encodings reuse one block.

---
 rtl/hour_keeper_pkg.sv | 32 +++
 rtl/hour_keeper_if.sv | 30 +++
 rtl/hour_fmt.sv | 39 +++
 rtl/hour_keeper.sv | 81 ++++++++
 tb/tb_hour_keeper.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/hour_keeper_pkg.sv
// Shared clock-datapath definitions: BCD hour type, hour limit, indicator codes.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package hour_keeper_pkg;

  // BCD hour, tens digit in [7:4], units digit in [3:0]
  typedef logic [7:0] bcd_hour_t;

  localparam bcd_hour_t  HOUR_MAX_BCD = 8'h23;
  localparam logic [3:0] LINE_AM_DEF  = 4'hA;
  localparam logic [3:0] LINE_PM_DEF  = 4'hF;
  localparam logic [3:0] LINE_24_DEF  = 4'hB;

  // Both digits decimal and the value within a day
  function automatic logic bcd_hour_ok(input bcd_hour_t h);
    return (h[7:4] <= 4'd9) && (h[3:0] <= 4'd9) && (h <= HOUR_MAX_BCD);
  endfunction

  // Only called on values already known to be 00..23
  function automatic logic [4:0] bcd_to_bin(input bcd_hour_t h);
    return 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
  endfunction

  function automatic bcd_hour_t bin_to_bcd(input logic [4:0] b);
    bcd_hour_t r;
    if (b >= 5'd20)      r = {4'h2, 4'(b - 5'd20)};
    else if (b >= 5'd10) r = {4'h1, 4'(b - 5'd10)};
    else                 r = {4'h0, 4'(b)};
    return r;
  endfunction

endpackage

// File: rtl/hour_keeper_if.sv
// Control/status bundle between the button/minute layer and hour_keeper.
// Latency: n/a (wires only).
// Backpressure: none; every input is a one-cycle pulse or a level.
// master = driver of count/load requests, slave = hour_keeper.
interface hour_keeper_if;
  import hour_keeper_pkg::*;

  logic       carry_in;   // minute counter 59->00 pulse
  logic       inc;        // manual +1
  logic       dec;        // manual -1
  logic       load;       // load strobe
  bcd_hour_t  load_hour;  // BCD 24h value for load
  logic       trans;      // 1 = 12h display
  bcd_hour_t  hour24;     // registered 24h hour
  bcd_hour_t  hour_disp;  // registered display hour
  logic [3:0] line;       // registered indicator code
  logic       day_carry;  // day wrap pulse
  logic       load_err;   // rejected load pulse

  modport master (
    output carry_in, inc, dec, load, load_hour, trans,
    input  hour24, hour_disp, line, day_carry, load_err
  );

  modport slave (
    input  carry_in, inc, dec, load, load_hour, trans,
    output hour24, hour_disp, line, day_carry, load_err
  );

endinterface

// File: rtl/hour_fmt.sv
// Combinational 24h -> display hour mapper with AM/PM/24h indicator selection.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: hour24/trans in, three indicator codes in, hour_disp/line out.
module hour_fmt
  import hour_keeper_pkg::*;
(
  input  bcd_hour_t  hour24,
  input  logic       trans,
  input  logic [3:0] line_am,
  input  logic [3:0] line_pm,
  input  logic [3:0] line_24,
  output bcd_hour_t  hour_disp,
  output logic [3:0] line
);

  always_comb begin
    hour_disp = hour24;
    line      = line_24;
    if (trans) begin
      line = line_am;
      if (hour24 == 8'h00) begin
        hour_disp = 8'h12;
      end else if (hour24 >= 8'h12) begin
        line = line_pm;
        case (hour24[7:4])
          // 12 stays 12; 13..19 drop to 01..07 by subtracting 12 digit-wise
          4'h1: hour_disp = (hour24[3:0] == 4'd2) ? 8'h12
                                                  : {4'h0, hour24[3:0] - 4'd2};
          // 20/21 need a units add of 8 (12 = 20 - 8 would borrow); 22/23 -> 10/11
          4'h2: hour_disp = (hour24[3:0] < 4'd2) ? {4'h0, hour24[3:0] + 4'd8}
                                                 : {4'h1, hour24[3:0] - 4'd2};
          default: hour_disp = hour24;
        endcase
      end
    end
  end

endmodule

// File: rtl/hour_keeper.sv
// Registered BCD hour-of-day counter with set/inc/dec and 12h/24h display.
// Latency: 1 cycle from any input to every output.
// Backpressure: none; pulses are consumed the cycle they arrive.
// Ports: clk, rst (async, active-high), bus (hour_keeper_if.slave).
module hour_keeper
  import hour_keeper_pkg::*;
#(
  parameter bcd_hour_t  RST_HOUR = 8'h00,
  parameter logic [3:0] LINE_AM  = LINE_AM_DEF,
  parameter logic [3:0] LINE_PM  = LINE_PM_DEF,
  parameter logic [3:0] LINE_24  = LINE_24_DEF
) (
  input logic          clk,
  input logic          rst,
  hour_keeper_if.slave bus
);

  bcd_hour_t  hour24_q, disp_q, nxt_hour, nxt_disp;
  logic [3:0] line_q, nxt_line;
  logic       dc_q, le_q, nxt_dc, nxt_le;
  logic [5:0] sum;
  logic [4:0] res;

  // Step is carry+inc-dec in -1..+2; the +24 bias keeps the sum non-negative
  // so the modulo reduces to at most two conditional subtracts.
  always_comb begin
    sum      = 6'(bcd_to_bin(hour24_q)) + 6'(bus.carry_in) + 6'(bus.inc)
             + 6'd24 - 6'(bus.dec);
    res      = 5'(sum);
    nxt_hour = hour24_q;
    nxt_dc   = 1'b0;
    nxt_le   = 1'b0;
    if (bus.load) begin
      if (bcd_hour_ok(bus.load_hour)) nxt_hour = bus.load_hour;
      else                            nxt_le   = 1'b1;
    end else begin
      if (sum >= 6'd48) begin
        res    = 5'(sum - 6'd48);
        // a forward wrap only counts as a new day when the minute carry drove it
        nxt_dc = bus.carry_in;
      end else if (sum >= 6'd24) begin
        res = 5'(sum - 6'd24);
      end
      nxt_hour = bin_to_bcd(res);
    end
  end

  // Display follows the next hour so hour24 and hour_disp change together
  hour_fmt u_fmt (
    .hour24    (nxt_hour),
    .trans     (bus.trans),
    .line_am   (LINE_AM),
    .line_pm   (LINE_PM),
    .line_24   (LINE_24),
    .hour_disp (nxt_disp),
    .line      (nxt_line)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hour24_q <= RST_HOUR;
      disp_q   <= RST_HOUR;
      line_q   <= LINE_24;
      dc_q     <= 1'b0;
      le_q     <= 1'b0;
    end else begin
      hour24_q <= nxt_hour;
      disp_q   <= nxt_disp;
      line_q   <= nxt_line;
      dc_q     <= nxt_dc;
      le_q     <= nxt_le;
    end
  end

  assign bus.hour24    = hour24_q;
  assign bus.hour_disp = disp_q;
  assign bus.line      = line_q;
  assign bus.day_carry = dc_q;
  assign bus.load_err  = le_q;

endmodule

// File: tb/tb_hour_keeper.sv
// Scoreboard bench for hour_keeper: directed vectors push expected outputs,
// a monitor pops and compares one entry after each clock edge.
module tb_hour_keeper;
  import hour_keeper_pkg::*;

  typedef struct packed {
    logic [7:0] h24;
    logic [7:0] disp;
    logic [3:0] line;
    logic       dc;
    logic       le;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  hour_keeper_if bus();

  hour_keeper #(
    .RST_HOUR (8'h00),
    .LINE_AM  (4'hA),
    .LINE_PM  (4'hF),
    .LINE_24  (4'hB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, queue the outputs expected after the next posedge
  task automatic drive(input logic r, c, i, d, l, input logic [7:0] lh, input logic t,
                       input logic [7:0] e24, input logic [7:0] ed, input logic [3:0] el,
                       input logic edc, input logic ele);
    exp_t e;
    @(negedge clk);
    rst = r; bus.carry_in = c; bus.inc = i; bus.dec = d;
    bus.load = l; bus.load_hour = lh; bus.trans = t;
    e.h24 = e24; e.disp = ed; e.line = el; e.dc = edc; e.le = ele;
    q.push_back(e);
    @(posedge clk);
  endtask

  // 24h idle cycle with hour h expected
  task automatic idle24(input logic [7:0] h);
    drive(0, 0, 0, 0, 0, 8'h00, 0, h, h, 4'hB, 0, 0);
  endtask

  // 24h load of a valid value
  task automatic load24(input logic [7:0] h);
    drive(0, 0, 0, 0, 1, h, 0, h, h, 4'hB, 0, 0);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // 12h clock face: midnight and noon read 12, afternoon subtracts 12
  function automatic logic [7:0] face12(input int h);
    int v;
    if (h == 0)       v = 12;
    else if (h <= 12) v = h;
    else              v = h - 12;
    return to_bcd(v);
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hour24",    bus.hour24,           e.h24);
        chk("hour_disp", bus.hour_disp,        e.disp);
        chk("line",      {4'h0, bus.line},     {4'h0, e.line});
        chk("day_carry", {7'h0, bus.day_carry}, {7'h0, e.dc});
        chk("load_err",  {7'h0, bus.load_err},  {7'h0, e.le});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.carry_in = 0; bus.inc = 0; bus.dec = 0; bus.load = 0;
    bus.load_hour = 8'h00; bus.trans = 1;

    // reset held with 12h selected, then first edge after release maps 00 -> 12 AM
    drive(1, 0, 0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 4'hB, 0, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 1, 8'h00, 8'h12, 4'hA, 0, 0);

    // minute carry wraps the day; inc alone does not flag it
    load24(8'h23);
    drive(0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 4'hB, 1, 0);
    idle24(8'h00);
    load24(8'h23);
    drive(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 4'hB, 0, 0);

    // double step across the wrap and across a units carry
    load24(8'h22);
    drive(0, 1, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 4'hB, 1, 0);
    load24(8'h09);
    drive(0, 1, 1, 0, 0, 8'h00, 0, 8'h11, 8'h11, 4'hB, 0, 0);
    drive(0, 1, 1, 0, 0, 8'h00, 0, 8'h13, 8'h13, 4'hB, 0, 0);

    // decrement borrows
    load24(8'h00);
    drive(0, 0, 0, 1, 0, 8'h00, 0, 8'h23, 8'h23, 4'hB, 0, 0);
    load24(8'h10);
    drive(0, 0, 0, 1, 0, 8'h00, 0, 8'h09, 8'h09, 4'hB, 0, 0);

    // zero net step holds
    drive(0, 0, 1, 1, 0, 8'h00, 0, 8'h09, 8'h09, 4'hB, 0, 0);
    drive(0, 1, 0, 1, 0, 8'h00, 0, 8'h09, 8'h09, 4'hB, 0, 0);

    // units carry 19 -> 20
    load24(8'h19);
    drive(0, 0, 1, 0, 0, 8'h00, 0, 8'h20, 8'h20, 4'hB, 0, 0);

    // rejected loads hold, back-to-back error pulses; valid load beats inc
    drive(0, 0, 0, 0, 1, 8'h24, 0, 8'h20, 8'h20, 4'hB, 0, 1);
    drive(0, 0, 0, 0, 1, 8'h1A, 0, 8'h20, 8'h20, 4'hB, 0, 1);
    drive(0, 0, 1, 0, 1, 8'h21, 1, 8'h21, 8'h09, 4'hF, 0, 0);
    // load beats carry_in at 23: no advance, no day_carry
    drive(0, 1, 0, 0, 1, 8'h23, 0, 8'h23, 8'h23, 4'hB, 0, 0);

    // full-day sweep in 12h mode via minute carry
    drive(0, 0, 0, 0, 1, 8'h00, 1, 8'h00, 8'h12, 4'hA, 0, 0);
    for (int h = 1; h < 24; h++)
      drive(0, 1, 0, 0, 0, 8'h00, 1, to_bcd(h), face12(h), (h < 12) ? 4'hA : 4'hF, 0, 0);
    drive(0, 1, 0, 0, 0, 8'h00, 1, 8'h00, 8'h12, 4'hA, 1, 0);

    // trans toggle with no count event
    drive(0, 0, 0, 0, 1, 8'h15, 1, 8'h15, 8'h03, 4'hF, 0, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 0, 8'h15, 8'h15, 4'hB, 0, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 1, 8'h15, 8'h03, 4'hF, 0, 0);

    // asynchronous reset mid-operation with carry_in high at 23
    drive(0, 0, 0, 0, 1, 8'h23, 1, 8'h23, 8'h11, 4'hF, 0, 0);
    @(negedge clk);
    bus.carry_in = 1; bus.load = 0;
    rst = 1;
    #1;
    chk("async_rst_hour24",    bus.hour24,            8'h00);
    chk("async_rst_hour_disp", bus.hour_disp,         8'h00);
    chk("async_rst_line",      {4'h0, bus.line},      8'h0B);
    chk("async_rst_day_carry", {7'h0, bus.day_carry}, 8'h00);
    @(posedge clk);
    drive(1, 1, 0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 4'hB, 0, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 1, 8'h00, 8'h12, 4'hA, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
